// File: rtl/display_mux_hex.sv
// Time-multiplexed active-low hex driver for a bank of common-anode 7-segment displays.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module display_mux_hex #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    enable,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [6:0]              segs,
  output logic                    dp,
  output logic [IDX_W-1:0]        digit_idx
);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tick;
  logic [NUM_DIGITS-1:0] blank_eff;
  logic [NUM_DIGITS-1:0] sel;
  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
  logic [6:0]            segs_q, segs_d;
  logic                  dp_q, dp_d;

  // Unknown nibbles fall through to the dark pattern.
  function automatic logic [6:0] hex_to_segs(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_segs = 7'b0000001;
      4'h1:    hex_to_segs = 7'b1001111;
      4'h2:    hex_to_segs = 7'b0010010;
      4'h3:    hex_to_segs = 7'b0000110;
      4'h4:    hex_to_segs = 7'b1001100;
      4'h5:    hex_to_segs = 7'b0100100;
      4'h6:    hex_to_segs = 7'b0100000;
      4'h7:    hex_to_segs = 7'b0001101;
      4'h8:    hex_to_segs = 7'b0000000;
      4'h9:    hex_to_segs = 7'b0000100;
      4'hA:    hex_to_segs = 7'b0001000;
      4'hB:    hex_to_segs = 7'b1100000;
      4'hC:    hex_to_segs = 7'b0110001;
      4'hD:    hex_to_segs = 7'b1000010;
      4'hE:    hex_to_segs = 7'b0110000;
      4'hF:    hex_to_segs = 7'b0111000;
      default: hex_to_segs = 7'b1111111;
    endcase
  endfunction

  // Prescaler and scan index; the index keeps moving while the display is disabled.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      tick  = 1'b1;
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (tick) begin
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Effective per-digit blanking, optionally including leading-zero suppression.
  always_comb begin
    blank_eff = blank;
`ifdef LEADING_ZERO_BLANK_EN
    begin : lzb
      logic higher_zero;
      higher_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        higher_zero  = higher_zero & (value[4*i +: 4] == 4'h0);
        blank_eff[i] = blank[i] | higher_zero;
      end
    end
`else
    blank_eff = blank;
`endif
  end

  // Select the current digit; sel is one-hot by construction, so at most one anode is low.
  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b1;
    cur_dp    = 1'b0;
    sel       = {NUM_DIGITS{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel[i]    = 1'b1;
        cur_nib   = value[4*i +: 4];
        cur_blank = blank_eff[i];
        cur_dp    = dp_in[i];
      end else begin
        sel[i] = 1'b0;
      end
    end
    if (enable && !cur_blank) begin
      anodes_d = ~sel;
      segs_d   = hex_to_segs(cur_nib);
      dp_d     = ~cur_dp;
    end else begin
      anodes_d = {NUM_DIGITS{1'b1}};
      segs_d   = 7'b1111111;
      dp_d     = 1'b1;
    end
  end

  // State and pin registers; reset darkens the pins without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= {CNT_W{1'b0}};
      idx_q    <= {IDX_W{1'b0}};
      anodes_q <= {NUM_DIGITS{1'b1}};
      segs_q   <= 7'b1111111;
      dp_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      anodes_q <= anodes_d;
      segs_q   <= segs_d;
      dp_q     <= dp_d;
    end
  end

  assign anodes    = anodes_q;
  assign segs      = segs_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_display_mux_hex.sv
// Scoreboard bench for display_mux_hex (4 digits, 4-cycle refresh slots).
module tb_display_mux_hex;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        enable = 1'b1;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  anodes;
  logic [6:0]  segs;
  logic        dp;
  logic [1:0]  digit_idx;

  int errors = 0;
  int checks = 0;
  int cnt_m = 0;
  int idx_m = 0;
  logic [11:0] exp_q[$];
  int          idx_q[$];

  display_mux_hex #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .enable(enable), .dp_in(dp_in),
    .blank(blank), .anodes(anodes), .segs(segs), .dp(dp), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001101;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  4'hF: return 7'b0111000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {anodes, segs, dp} for the given scan index and current inputs.
  function automatic logic [11:0] expect_out(input int idx);
    logic       blk;
    logic [3:0] an;
    blk = blank[idx];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (value >> (4 * idx)) == 16'h0000) blk = 1'b1;
`endif
    if (!enable || blk) return {4'hF, 7'h7F, 1'b1};
    an = 4'hF;
    an[idx] = 1'b0;
    return {an, seg_of(value[4*idx +: 4]), ~dp_in[idx]};
  endfunction

  // Push expectation, clock once, advance the reference scan model.
  task automatic cycle();
    exp_q.push_back(expect_out(idx_m));
    @(posedge clk);
    if (cnt_m == RD - 1) begin
      cnt_m = 0;
      idx_m = (idx_m == ND - 1) ? 0 : idx_m + 1;
    end else begin
      cnt_m++;
    end
    idx_q.push_back(idx_m);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({anodes, segs, dp} !== {4'hF, 7'h7F, 1'b1})
      $display("FAIL reset_out got=%b exp=%b", {anodes, segs, dp}, {4'hF, 7'h7F, 1'b1});
    checks++;
    if ({anodes, segs, dp} !== {4'hF, 7'h7F, 1'b1}) errors++;
    checks--;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (digit_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_idx got=%0d exp=0", digit_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt_m = 0;
    idx_m = 0;
  endtask

  task automatic test_scan();
    logic [11:0] e;
    int          ie;
    value = 16'h12AF;
    dp_in = 4'b0100;
    blank = 4'b0000;
    enable = 1'b1;
    for (int k = 0; k < 2 * ND * RD + 2; k++) begin
      cycle();
      e = exp_q.pop_front();
      ie = idx_q.pop_front();
      checks++;
      if ({anodes, segs, dp} !== e) begin
        errors++;
        $display("FAIL scan k=%0d got=%b exp=%b", k, {anodes, segs, dp}, e);
      end
      checks++;
      if (digit_idx !== ie[1:0]) begin
        errors++;
        $display("FAIL scan_idx k=%0d got=%0d exp=%0d", k, digit_idx, ie);
      end
    end
  endtask

  task automatic test_blank_and_zeros();
    logic [11:0] e;
    dp_in = 4'b0000;
    for (int k = 0; k < 2 * ND * RD; k++) begin
      if (k < ND * RD) begin
        value = 16'h8888;
        blank = 4'b1000;
      end else begin
        value = (k < ND * RD + 2 * RD) ? 16'h0040 : 16'h0000;
        blank = 4'b0000;
      end
      cycle();
      e = exp_q.pop_front();
      void'(idx_q.pop_front());
      checks++;
      if ({anodes, segs, dp} !== e) begin
        errors++;
        $display("FAIL blank k=%0d val=%h got=%b exp=%b", k, value, {anodes, segs, dp}, e);
      end
    end
  endtask

  task automatic test_enable();
    logic [11:0] e;
    int          ie;
    value = 16'h3C5D;
    blank = 4'b0000;
    dp_in = 4'b0011;
    for (int k = 0; k < 26; k++) begin
      enable = !(k >= 5 && k < 15);
      cycle();
      e = exp_q.pop_front();
      ie = idx_q.pop_front();
      checks++;
      if ({anodes, segs, dp} !== e || (!enable && anodes !== 4'hF)) begin
        errors++;
        $display("FAIL enable k=%0d got=%b exp=%b", k, {anodes, segs, dp}, e);
      end
      checks++;
      if (digit_idx !== ie[1:0]) begin
        errors++;
        $display("FAIL enable_idx k=%0d got=%0d exp=%0d", k, digit_idx, ie);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    for (int k = 0; k < 40; k++) begin
      value = 16'($urandom);
      dp_in = 4'($urandom);
      blank = 4'($urandom_range(0, 15)) & 4'($urandom);
      cycle();
      e = exp_q.pop_front();
      void'(idx_q.pop_front());
      checks++;
      if ({anodes, segs, dp} !== e) begin
        errors++;
        $display("FAIL b2b k=%0d got=%b exp=%b", k, {anodes, segs, dp}, e);
      end
      checks++;
      if (anodes != 4'hF && $countones(~anodes) != 1) begin
        errors++;
        $display("FAIL onehot k=%0d got=%b exp=one_low", k, anodes);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] e;
    int          ie;
    value = 16'h7777;
    blank = 4'b0000;
    dp_in = 4'b1111;
    enable = 1'b1;
    repeat (5) begin
      cycle();
      void'(exp_q.pop_front());
      void'(idx_q.pop_front());
    end
    checks++;
    if (anodes === 4'hF) begin
      errors++;
      $display("FAIL pre_reset_lit got=%b exp=not_1111", anodes);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({anodes, segs, dp, digit_idx} !== {4'hF, 7'h7F, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b", {anodes, segs, dp, digit_idx},
               {4'hF, 7'h7F, 1'b1, 2'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt_m = 0;
    idx_m = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      e = exp_q.pop_front();
      ie = idx_q.pop_front();
      checks++;
      if ({anodes, segs, dp} !== e || digit_idx !== ie[1:0]) begin
        errors++;
        $display("FAIL restart k=%0d got=%b/%0d exp=%b/%0d", k, {anodes, segs, dp},
                 digit_idx, e, ie);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank_and_zeros();
    test_enable();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
